// File: rtl/layer_cycle_profiler_if.sv
// layer_cycle_profiler_if
// Pop-handshake bundle between the layer profiler FIFO and the okFP readout.
//   rd_en    : pop request from the reader
//   rd_valid : FIFO holds at least one entry
//   rd_data  : show-ahead head entry {layer_idx[5:0], cycle_cnt}, 0 when empty
// Modports: master = profiler (FIFO owner), slave = readout logic.
interface layer_cycle_profiler_if;
    logic        rd_en;
    logic        rd_valid;
    logic [31:0] rd_data;

    modport master (
        input  rd_en,
        output rd_valid,
        output rd_data
    );

    modport slave (
        output rd_en,
        input  rd_valid,
        input  rd_data
    );
endinterface

// File: rtl/layer_cycle_profiler.sv
// layer_cycle_profiler
// Measures the chip-cycle latency of each start_layer/done_layer pair and pushes one
// {layer_idx, cycle_cnt} word per completed layer into a show-ahead FIFO for okFP readout.
// Ports:
//   chip_clk, rst     : clock and synchronous active-high reset
//   start_layer       : layer start pulse from the run controller
//   done_layer        : layer done pulse from the chip
//   n_layers          : layers per network (0 means 64), sampled live
//   clear             : flush FIFO, layer index and sticky flags; forces idle
//   timeout_limit     : watchdog limit in cycles, 0 disables
//   rd                : pop handshake (rd_en / rd_valid / rd_data)
//   fifo_count        : number of stored entries
//   busy              : a layer is being measured
//   overflow, timeout : sticky flags
// Build option: define LAYER_PROF_WATCHDOG_EN to enable the timeout watchdog; otherwise
// timeout is tied to 0 and timeout_limit is ignored.
module layer_cycle_profiler #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned CNT_W      = 26
) (
    input  logic                         chip_clk,
    input  logic                         rst,
    input  logic                         start_layer,
    input  logic                         done_layer,
    input  logic [5:0]                   n_layers,
    input  logic                         clear,
    input  logic [31:0]                  timeout_limit,
    layer_cycle_profiler_if.master       rd,
    output logic [DEPTH_LOG2:0]          fifo_count,
    output logic                         busy,
    output logic                         overflow,
    output logic                         timeout
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CNT_W-1:0]      CntOne = 1;
    localparam logic [CNT_W-1:0]      CntMax = '1;
    localparam logic [DEPTH_LOG2-1:0] PtrOne = 1;
    localparam logic [DEPTH_LOG2:0]   FillOne = 1;

    typedef enum logic {S_IDLE, S_MEASURE} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [5:0]            layer_idx_q, layer_idx_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [31:0]           mem [DEPTH];

    logic       push, pop, wr_en, drop, full, empty;
    logic [5:0] last_idx;

    // Measurement FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_layer) begin
                    state_d = S_MEASURE;
                    cnt_d   = CntOne;
                end
            end
            S_MEASURE: begin
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
                if (done_layer) begin
                    push = 1'b1;
                    if (start_layer) begin
                        cnt_d = CntOne;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
        if (clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // Count can only reach DEPTH, so its MSB alone marks full.
    assign full     = count_q[DEPTH_LOG2];
    assign empty    = (count_q == '0);
    assign last_idx = n_layers - 6'd1;  // n_layers == 0 yields 63, i.e. 64 layers

    // FIFO and layer index next-state; clear overrides push and pop.
    always_comb begin
        pop  = rd.rd_en && !empty && !clear;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        wr_en = push && !clear && (!full || pop);
        drop  = push && !clear && full && !pop;

        wr_ptr_d    = wr_en ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
        count_d     = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + FillOne;
        end else if (pop && !wr_en) begin
            count_d = count_q - FillOne;
        end
        layer_idx_d = layer_idx_q;
        if (push) begin
            layer_idx_d = (layer_idx_q == last_idx) ? 6'd0 : layer_idx_q + 6'd1;
        end
        overflow_d  = overflow_q | drop;

        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            layer_idx_d = '0;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge chip_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            layer_idx_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            layer_idx_q <= layer_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage carries no reset; entries are only visible through count_q.
    always_ff @(posedge chip_clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {layer_idx_q, cnt_q};
        end
    end

`ifdef LAYER_PROF_WATCHDOG_EN
    logic        timeout_q, timeout_d, wd_hit;
    logic [31:0] cnt_ext;

    assign cnt_ext = 32'(cnt_q);
    // Flag reads high in the very cycle the count reaches the limit, then stays sticky.
    assign wd_hit    = (state_q == S_MEASURE) && (timeout_limit != 32'd0) &&
                       (cnt_ext == timeout_limit);
    assign timeout_d = clear ? 1'b0 : (timeout_q | wd_hit);
    assign timeout   = timeout_q | wd_hit;

    always_ff @(posedge chip_clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
`else
    logic unused_timeout_limit;
    assign unused_timeout_limit = ^timeout_limit;
    assign timeout              = 1'b0;
`endif

    assign rd.rd_valid = !empty;
    assign rd.rd_data  = empty ? 32'd0 : mem[rd_ptr_q];
    assign fifo_count  = count_q;
    assign busy        = (state_q == S_MEASURE);
    assign overflow    = overflow_q;

endmodule
